attr_elastic_pipeline: RTL and testbench

- Parametrised valid/ready elastic register pipeline of DEPTH stages, each WIDTH bits wide.
- Provides an occupancy count, a synchronous flush and a wrapping output-transfer counter.
- Serves as the hierarchical, sequential test design for the netlist Verilog backend and round-trip flows.
- Every stage is a separate instance carrying attributes, so attribute emission on modules, nets and instances is exercised on a design with real behaviour.

---
 rtl/attr_elastic_pipeline.sv | 104 ++++++++++
 tb/tb_attr_elastic_pipeline.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/attr_elastic_pipeline.sv
// rtl/attr_elastic_pipeline.sv - elastic valid/ready register pipeline with attributed stages
module attr_pipe_stage #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             ready,
  input  logic             prev_valid,
  input  logic [WIDTH-1:0] prev_data,
  output logic             valid,
  output logic [WIDTH-1:0] data
);
  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
      data  <= '0;
    end else if (flush) begin
      valid <= 1'b0;
    end else if (ready) begin
      valid <= prev_valid;
      // A bubble advances without overwriting the held payload.
      if (prev_valid) data <= prev_data;
    end
  end
endmodule

(* PIPE_DEPTH = DEPTH *)
module attr_elastic_pipeline #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 3,
  parameter int CNT_W = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH-1:0]           in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           out_data,
  output logic [$clog2(DEPTH+1)-1:0] occupancy,
  output logic [CNT_W-1:0]           xfer_count
);
  localparam int OCC_W = $clog2(DEPTH + 1);

  (* PIPE_NET = "stage" *) logic [DEPTH-1:0] stage_valid;
  (* PIPE_NET = "stage" *) logic [WIDTH-1:0] stage_data [DEPTH];
  logic [DEPTH-1:0] feed_valid;
  logic [WIDTH-1:0] feed_data [DEPTH];
  logic [DEPTH:0]   ready;

  // Resolved from the output end back so a stage frees up in the same cycle its successor drains.
  always_comb begin
    ready        = '0;
    ready[DEPTH] = out_ready;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      ready[i] = !stage_valid[i] || ready[i+1];
    end
  end

  assign in_ready      = ready[0] && !flush && !rst;
  assign feed_valid[0] = in_valid && in_ready;
  assign feed_data[0]  = in_data;

  for (genvar gi = 1; gi < DEPTH; gi++) begin : g_link
    assign feed_valid[gi] = stage_valid[gi-1];
    assign feed_data[gi]  = stage_data[gi-1];
  end

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
    (* PIPE_STAGE = gi *)
    attr_pipe_stage #(.WIDTH(WIDTH)) u_stage (
      .clk        (clk),
      .rst        (rst),
      .flush      (flush),
      .ready      (ready[gi]),
      .prev_valid (feed_valid[gi]),
      .prev_data  (feed_data[gi]),
      .valid      (stage_valid[gi]),
      .data       (stage_data[gi])
    );
  end

  assign out_valid = stage_valid[DEPTH-1];
  assign out_data  = stage_data[DEPTH-1];

  always_comb begin
    occupancy = '0;
    for (int i = 0; i < DEPTH; i++) begin
      occupancy = occupancy + OCC_W'(stage_valid[i]);
    end
  end

  // Transfers during a flush cycle still count; the counter wraps freely.
  always_ff @(posedge clk) begin
    if (rst) begin
      xfer_count <= '0;
    end else if (out_valid && out_ready) begin
      xfer_count <= xfer_count + CNT_W'(1);
    end
  end
endmodule

// File: tb/tb_attr_elastic_pipeline.sv
// tb/tb_attr_elastic_pipeline.sv - directed bench for attr_elastic_pipeline
module tb_attr_elastic_pipeline;
  logic clk = 1'b0;
  logic rst, flush, in_valid, out_ready;
  logic [7:0] in_data;

  logic in_ready3, out_valid3;
  logic [7:0] out_data3;
  logic [1:0] occ3;
  logic [15:0] xfer3;

  logic in_ready4, out_valid4;
  logic [7:0] out_data4;
  logic [1:0] occ4;
  logic [3:0] xfer4;

  logic in_ready1, out_valid1;
  logic [7:0] out_data1;
  logic [0:0] occ1;
  logic [15:0] xfer1;

  int total = 0;
  int bad = 0;
  int exp_x = 0;
  logic [7:0] feedq[$];
  logic [7:0] expq[$];

  always #5 clk = ~clk;

  attr_elastic_pipeline #(.WIDTH(8), .DEPTH(3), .CNT_W(16)) u3 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready3),
    .in_data(in_data), .out_valid(out_valid3), .out_ready(out_ready), .out_data(out_data3),
    .occupancy(occ3), .xfer_count(xfer3));

  attr_elastic_pipeline #(.WIDTH(8), .DEPTH(3), .CNT_W(4)) u4 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready4),
    .in_data(in_data), .out_valid(out_valid4), .out_ready(out_ready), .out_data(out_data4),
    .occupancy(occ4), .xfer_count(xfer4));

  attr_elastic_pipeline #(.WIDTH(8), .DEPTH(1), .CNT_W(16)) u1 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready1),
    .in_data(in_data), .out_valid(out_valid1), .out_ready(out_ready), .out_data(out_data1),
    .occupancy(occ1), .xfer_count(xfer1));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Feeds feedq with proper handshaking and checks every output transfer against expq.
  task automatic run(input int cycles);
    logic acc, xf;
    for (int c = 0; c < cycles; c++) begin
      in_valid = (feedq.size() != 0);
      in_data  = in_valid ? feedq[0] : 8'h00;
      #1;
      acc = in_valid && in_ready3;
      xf  = out_valid3 && out_ready;
      if (xf) begin
        chk("xfer_expected", 32'(expq.size() != 0), 32'd1);
        if (expq.size() != 0) chk("out_data_order", out_data3, expq.pop_front());
      end
      step();
      if (acc) void'(feedq.pop_front());
      if (xf) begin
        exp_x++;
        chk("xfer_count", xfer3, exp_x);
        chk("xfer_count_w4", xfer4, exp_x % 16);
      end
    end
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b0;

    #1;
    chk("rst_in_ready", in_ready3, 0);
    chk("rst_in_ready_d1", in_ready1, 0);
    step();
    step();
    chk("rst_out_valid", out_valid3, 0);
    chk("rst_out_data", out_data3, 0);
    chk("rst_occupancy", occ3, 0);
    chk("rst_xfer", xfer3, 0);
    chk("rst_out_valid_d1", out_valid1, 0);
    rst = 1'b0;

    out_ready = 1'b1;
    for (int c = 0; c < 14; c++) begin
      in_valid = (c < 10);
      in_data  = 8'(c + 1);
      #1;
      if (c < 10) begin
        chk("stream_in_ready", in_ready3, 1);
        chk("stream_in_ready_w4", in_ready4, 1);
        chk("stream_in_ready_d1", in_ready1, 1);
      end
      chk("stream_out_valid", out_valid3, (c >= 3 && c < 13));
      if (c >= 3 && c < 13) chk("stream_out_data", out_data3, c - 2);
      chk("d1_out_valid", out_valid1, (c >= 1 && c < 11));
      if (c >= 1 && c < 11) chk("d1_out_data", out_data1, c);
      step();
    end
    in_valid = 1'b0;
    exp_x = 10;
    chk("stream_xfer", xfer3, 10);
    chk("stream_xfer_w4", xfer4, 10);
    chk("d1_xfer", xfer1, 10);

    out_ready = 1'b0;
    for (int k = 0; k < 5; k++) feedq.push_back(8'(8'hA0 + k));
    run(6);
    chk("bp_accepted_left", feedq.size(), 2);
    chk("bp_occupancy", occ3, 3);
    in_valid = 1'b1; in_data = 8'hA3;
    #1;
    chk("bp_in_ready", in_ready3, 0);
    chk("bp_out_valid", out_valid3, 1);
    chk("bp_out_data_held", out_data3, 8'hA0);
    run(1);
    chk("bp_out_data_held2", out_data3, 8'hA0);
    chk("bp_xfer_held", xfer3, 10);
    for (int k = 0; k < 5; k++) expq.push_back(8'(8'hA0 + k));
    out_ready = 1'b1;
    run(8);
    chk("bp_all_out", expq.size(), 0);
    chk("bp_all_in", feedq.size(), 0);
    chk("wrap_15", xfer4, 15);

    out_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      in_valid = (c % 2 == 0);
      in_data  = (c % 2 == 1) ? 8'hEE : 8'(8'h11 * (c / 2 + 1));
      #1;
      chk("bubble_in_ready", in_ready3, 1);
      step();
    end
    in_valid = 1'b0;
    chk("bubble_occupancy", occ3, 3);
    chk("bubble_head", out_data3, 8'h11);
    expq.push_back(8'h11); expq.push_back(8'h22); expq.push_back(8'h33);
    out_ready = 1'b1;
    run(5);
    chk("bubble_all_out", expq.size(), 0);
    chk("bubble_empty", occ3, 0);
    chk("wrap_after_18", xfer4, 2);

    out_ready = 1'b0;
    feedq.push_back(8'h51); feedq.push_back(8'h52); feedq.push_back(8'h53);
    run(3);
    chk("flush_pre_occ", occ3, 3);
    chk("flush_pre_occ_w4", occ4, 3);
    flush = 1'b1; out_ready = 1'b1; in_valid = 1'b1; in_data = 8'h54;
    #1;
    chk("flush_in_ready", in_ready3, 0);
    chk("flush_out_valid", out_valid3, 1);
    chk("flush_out_data", out_data3, 8'h51);
    step();
    flush = 1'b0; in_valid = 1'b0;
    #1;
    chk("flush_occ", occ3, 0);
    chk("flush_out_valid_after", out_valid3, 0);
    chk("flush_xfer", xfer3, 19);
    chk("flush_xfer_w4", xfer4, 3);
    step();
    chk("flush_no_accept", occ3, 0);
    chk("flush_xfer_stable", xfer3, 19);

    out_ready = 1'b0;
    feedq.push_back(8'h61); feedq.push_back(8'h62);
    run(2);
    chk("rst_mid_pre_occ", occ3, 2);
    rst = 1'b1; flush = 1'b1; out_ready = 1'b1; in_valid = 1'b1; in_data = 8'h63;
    #1;
    chk("rst_mid_in_ready", in_ready3, 0);
    chk("rst_mid_in_ready_d1", in_ready1, 0);
    step();
    chk("rst_mid_occ", occ3, 0);
    chk("rst_mid_out_valid", out_valid3, 0);
    chk("rst_mid_out_data", out_data3, 0);
    chk("rst_mid_xfer", xfer3, 0);
    chk("rst_mid_xfer_w4", xfer4, 0);
    chk("rst_mid_out_valid_w4", out_valid4, 0);
    chk("rst_mid_out_data_w4", out_data4, 0);
    chk("rst_mid_xfer_d1", xfer1, 0);
    chk("rst_mid_occ_d1", occ1, 0);
    chk("rst_mid_out_data_d1", out_data1, 0);
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0;
    step();
    chk("post_rst_occ", occ3, 0);
    chk("post_rst_out_valid", out_valid3, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
